// File: rtl/baud_pkg.sv
// Shared types and elaboration helpers for the baud/oversample strobe generator.
package baud_pkg;

  typedef int unsigned rate_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StApplied
  } req_state_e;

  // Wide enough that acc + inc (both < clk_hz) never wraps.
  function automatic int unsigned acc_width(input int unsigned clk_hz);
    return $clog2(clk_hz) + 1;
  endfunction

  function automatic logic [63:0] baud_inc(input logic [63:0] base, input rate_idx_t idx,
                                           input int unsigned os);
    return (base << idx) * 64'(os);
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/strobe bundle between the UART register block (master) and the generator (slave).
interface baud_tick_gen_if #(
  parameter int unsigned RATE_W = 3,
  parameter int unsigned OS_W   = 4
);
  logic              enable;
  logic              sync;
  logic [RATE_W-1:0] rate_sel;
  logic              rate_req;
  logic              rate_ack;
  logic [RATE_W-1:0] active_rate;
  logic              s_tick;
  logic              mid_tick;
  logic              tick;
  logic [OS_W-1:0]   os_count;

  modport master (
    output enable, sync, rate_sel, rate_req,
    input  rate_ack, active_rate, s_tick, mid_tick, tick, os_count
  );

  modport slave (
    input  enable, sync, rate_sel, rate_req,
    output rate_ack, active_rate, s_tick, mid_tick, tick, os_count
  );
endinterface

// File: rtl/baud_phase_acc.sv
// Fractional phase accumulator modulo CLK_HZ; overflow marks one oversample period elapsed.
module baud_phase_acc #(
  parameter int unsigned ACC_W  = 27,
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [ACC_W-1:0] load_val,
  input  logic [ACC_W-1:0] inc,
  output logic             overflow
);

  localparam logic [ACC_W-1:0] Modulus = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;
  logic             wrap;

  assign sum      = acc_q + inc;
  assign wrap     = (sum >= Modulus);
  // A load (phase re-sync) suppresses the overflow of the same cycle.
  assign overflow = enable && !load && wrap;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= load_val;
    end else if (enable) begin
      acc_q <= wrap ? (sum - Modulus) : sum;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud/oversample strobe generator: phase accumulator, oversample counter,
// registered strobes and a bit-boundary rate-change handshake.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BASE_BAUD  = 1200,
  parameter int unsigned RATE_W     = 3,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned RESET_RATE = 0
) (
  input logic           clock,
  input logic           reset,
  baud_tick_gen_if.slave bus
);

  localparam int unsigned ACC_W  = acc_width(CLK_HZ);
  localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
  localparam int unsigned NRATES = 2 ** RATE_W;

  localparam logic [ACC_W-1:0]  HalfStep   = ACC_W'(CLK_HZ / 2);
  localparam logic [OS_W-1:0]   OsLast     = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OsMid      = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [RATE_W-1:0] ResetRateV = RATE_W'(RESET_RATE);

  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : gen_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be even and >= 4");
  end

  // Per-rate increments are constants; a rate that cannot be represented fails elaboration.
  logic [ACC_W-1:0] inc_table [NRATES];

  for (genvar r = 0; r < NRATES; r++) begin : gen_inc
    localparam logic [63:0] RateInc = baud_inc(64'(BASE_BAUD), rate_idx_t'(r), OVERSAMPLE);
    if (RateInc >= 64'(CLK_HZ)) begin : gen_bad_rate
      $error("baud_tick_gen: rate increment not below CLK_HZ");
    end
    assign inc_table[r] = ACC_W'(RateInc);
  end

  logic              overflow;
  logic [ACC_W-1:0]  inc;

  logic              s_tick_q;
  logic              mid_tick_q;
  logic              tick_q;
  logic              rate_ack_q;
  logic [OS_W-1:0]   os_count_q;
  logic [RATE_W-1:0] active_rate_q;
  logic [RATE_W-1:0] pending_q;
  req_state_e        state_q;

  assign inc = inc_table[active_rate_q];

  baud_phase_acc #(
    .ACC_W  (ACC_W),
    .CLK_HZ (CLK_HZ)
  ) u_phase_acc (
    .clock    (clock),
    .reset    (reset),
    .enable   (bus.enable),
    .load     (bus.sync),
    .load_val (HalfStep),
    .inc      (inc),
    .overflow (overflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s_tick_q      <= 1'b0;
      mid_tick_q    <= 1'b0;
      tick_q        <= 1'b0;
      rate_ack_q    <= 1'b0;
      os_count_q    <= '0;
      active_rate_q <= ResetRateV;
      pending_q     <= '0;
      state_q       <= StIdle;
    end else begin
      s_tick_q   <= 1'b0;
      mid_tick_q <= 1'b0;
      tick_q     <= 1'b0;
      rate_ack_q <= 1'b0;

      if (bus.sync) begin
        os_count_q <= '0;
      end else if (overflow) begin
        s_tick_q   <= 1'b1;
        tick_q     <= (os_count_q == OsLast);
        mid_tick_q <= (os_count_q == OsMid);
        os_count_q <= (os_count_q == OsLast) ? '0 : os_count_q + OS_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          // The cycle showing rate_ack still sees rate_req high; do not relatch it.
          if (bus.rate_req && !rate_ack_q) begin
            pending_q <= bus.rate_sel;
            state_q   <= StPending;
          end
        end
        StPending: begin
          // Switch on the overflow that issues tick so the new bit starts at the new rate.
          if (!bus.enable || bus.sync || (overflow && (os_count_q == OsLast))) begin
            active_rate_q <= pending_q;
            state_q       <= StApplied;
          end
        end
        StApplied: begin
          rate_ack_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_tick      = s_tick_q;
  assign bus.mid_tick    = mid_tick_q;
  assign bus.tick        = tick_q;
  assign bus.rate_ack    = rate_ack_q;
  assign bus.os_count    = os_count_q;
  assign bus.active_rate = active_rate_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: 1.8432 MHz instance for exact periods and handshakes,
// 50 MHz instance for fractional-rate averaging.
module tb_baud_tick_gen;

  localparam int SelS   = 0;
  localparam int SelTk  = 1;
  localparam int SelMid = 2;
  localparam int SelAck = 3;

  logic clock = 1'b0;
  logic reset;
  logic reset_b;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  baud_tick_gen_if #(.RATE_W(2), .OS_W(4)) bus ();
  baud_tick_gen_if #(.RATE_W(3), .OS_W(4)) bus_b ();

  baud_tick_gen #(
    .CLK_HZ     (1_843_200),
    .BASE_BAUD  (1200),
    .RATE_W     (2),
    .OVERSAMPLE (16),
    .RESET_RATE (0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  baud_tick_gen #(
    .CLK_HZ     (50_000_000),
    .BASE_BAUD  (1200),
    .RATE_W     (3),
    .OVERSAMPLE (16),
    .RESET_RATE (3)
  ) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SelS:    return bus.s_tick;
      SelTk:   return bus.tick;
      SelMid:  return bus.mid_tick;
      default: return bus.rate_ack;
    endcase
  endfunction

  // Steps until the selected strobe is seen; n = budget on timeout (then the caller's check fails).
  task automatic wait_sig(input int sel, output int unsigned n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sig(sel) && n < 2000);
  endtask

  initial begin
    int unsigned n;
    int unsigned t0;
    int unsigned cnt;
    int unsigned cnt_t;
    int unsigned last;
    int unsigned min_gap;
    int unsigned max_gap;

    reset = 1'b1;
    reset_b = 1'b1;
    bus.enable = 1'b0;
    bus.sync = 1'b0;
    bus.rate_sel = '0;
    bus.rate_req = 1'b0;
    bus_b.enable = 1'b0;
    bus_b.sync = 1'b0;
    bus_b.rate_sel = '0;
    bus_b.rate_req = 1'b0;
    repeat (3) step();

    check("rst_s_tick", bus.s_tick, 0);
    check("rst_tick", bus.tick, 0);
    check("rst_mid_tick", bus.mid_tick, 0);
    check("rst_rate_ack", bus.rate_ack, 0);
    check("rst_os_count", bus.os_count, 0);
    check("rst_active_rate", bus.active_rate, 0);
    check("rst_b_active_rate", bus_b.active_rate, 3);

    // Rate 0 at 1.8432 MHz: increment divides CLK_HZ exactly, period 96.
    reset = 1'b0;
    bus.enable = 1'b1;
    wait_sig(SelS, n);
    check("r0_first_s_tick", n, 96);
    check("r0_first_os_count", bus.os_count, 1);
    wait_sig(SelS, n);
    check("r0_s_tick_period", n, 96);
    wait_sig(SelMid, n);
    check("r0_mid_latency", n, 576);
    check("r0_mid_os_count", bus.os_count, 8);
    check("r0_mid_with_s_tick", bus.s_tick, 1);
    check("r0_mid_not_tick", bus.tick, 0);
    wait_sig(SelTk, n);
    check("r0_first_tick", n, 768);
    check("r0_tick_os_count", bus.os_count, 0);
    check("r0_tick_with_s_tick", bus.s_tick, 1);
    check("r0_tick_not_mid", bus.mid_tick, 0);
    wait_sig(SelTk, n);
    check("r0_tick_period", n, 1536);

    // Mid-bit change to rate 3; a rate_sel change while pending must be ignored.
    repeat (100) step();
    bus.rate_sel = 2'd3;
    bus.rate_req = 1'b1;
    step();
    bus.rate_sel = 2'd1;
    wait_sig(SelTk, n);
    check("chg_wait_tick", n, 1435);
    check("chg_active_at_tick", bus.active_rate, 3);
    check("chg_no_ack_at_tick", bus.rate_ack, 0);
    t0 = cyc;
    step();
    check("chg_ack", bus.rate_ack, 1);
    bus.rate_req = 1'b0;
    wait_sig(SelS, n);
    check("chg_first_s_spacing", cyc - t0, 12);
    for (int i = 0; i < 10; i++) begin
      wait_sig(SelTk, n);
      check("r3_tick_period", cyc - t0, 192);
      t0 = cyc;
    end
    check("r3_active_kept", bus.active_rate, 3);

    // Sync landing on an overflow edge: strobe suppressed, half-step pre-load.
    repeat (23) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    t0 = cyc;
    check("sync_os_count", bus.os_count, 0);
    check("sync_s_tick_suppressed", bus.s_tick, 0);
    wait_sig(SelS, n);
    check("sync_first_s_tick", cyc - t0, 6);
    check("sync_first_os", bus.os_count, 1);
    wait_sig(SelTk, n);
    check("sync_first_tick", cyc - t0, 186);

    // Freeze for 50 cycles right after a strobe, then resume from the same phase.
    bus.enable = 1'b0;
    t0 = cyc;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.s_tick || bus.tick || bus.mid_tick) cnt++;
    end
    check("freeze_no_strobes", cnt, 0);
    check("freeze_os_count", bus.os_count, 0);
    bus.enable = 1'b1;
    wait_sig(SelS, n);
    check("resume_s_tick", cyc - t0, 62);

    // Reset while a request is pending: no ack, reset rate restored.
    wait_sig(SelTk, n);
    bus.rate_sel = 2'd1;
    bus.rate_req = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    check("rstp_active_rate", bus.active_rate, 0);
    check("rstp_rate_ack", bus.rate_ack, 0);
    check("rstp_s_tick", bus.s_tick, 0);
    check("rstp_os_count", bus.os_count, 0);
    reset = 1'b0;
    bus.rate_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rate_ack) cnt++;
    end
    check("rstp_no_ack_after", cnt, 0);

    // Disabled: request applies immediately; repeat of the active rate still acks.
    bus.enable = 1'b0;
    bus.rate_sel = 2'd2;
    bus.rate_req = 1'b1;
    t0 = cyc;
    wait_sig(SelAck, n);
    check("dis_ack_latency", cyc - t0, 3);
    check("dis_active_rate", bus.active_rate, 2);
    bus.rate_req = 1'b0;
    step();
    bus.rate_req = 1'b1;
    t0 = cyc;
    wait_sig(SelAck, n);
    check("same_rate_ack_latency", cyc - t0, 3);
    check("same_rate_active", bus.active_rate, 2);
    bus.rate_req = 1'b0;

    // Sync while disabled still pre-loads half a step (rate 2: 12 of 24 cycles).
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check("dis_sync_os_count", bus.os_count, 0);
    bus.enable = 1'b1;
    t0 = cyc;
    wait_sig(SelS, n);
    check("dis_sync_first_s_tick", cyc - t0, 12);

    // 50 MHz, rate 3: 153600/50e6 per cycle -> 61 s_ticks, 3 ticks, gaps 325/326.
    reset_b = 1'b0;
    bus_b.enable = 1'b1;
    cnt = 0;
    cnt_t = 0;
    last = 0;
    min_gap = 32'hffff_ffff;
    max_gap = 0;
    for (int unsigned i = 1; i <= 20000; i++) begin
      step();
      if (bus_b.s_tick) begin
        if (cnt != 0) begin
          if (i - last < min_gap) min_gap = i - last;
          if (i - last > max_gap) max_gap = i - last;
        end
        last = i;
        cnt++;
      end
      if (bus_b.tick) cnt_t++;
    end
    check("b_s_tick_count", cnt, 61);
    check("b_tick_count", cnt_t, 3);
    check("b_min_gap", min_gap, 325);
    check("b_max_gap", max_gap, 326);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
